reorder_buffer_mc: RTL and testbench

Parametrised successor to the single-commit reorder buffer. It keeps program order for up to ROB_DEPTH in-flight instructions and accepts one dispatch per cycle. It collects results from NUM_WB generic writeback channels and retires up to COMMIT_WIDTH instructions per cycle to the regfile. Stores drain to the data cache one at a time, and branch/JALR mispredicts resolve at commit with a full flush. Sits between decoder, CDB, regfile, data cache and branch predictor.

---
 rtl/reorder_buffer_mc_pkg.sv | 34 +++
 rtl/reorder_buffer_mc_if.sv | 67 ++++++
 rtl/reorder_buffer_mc_store_unit.sv | 88 ++++++++
 rtl/reorder_buffer_mc.sv | 205 ++++++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_mc_pkg.sv
// Shared types for the multi-commit reorder buffer: op kinds, store encodings,
// store FSM state codes and the per-entry record.
package reorder_buffer_mc_pkg;

  typedef enum logic [1:0] {
    OP_REG  = 2'd0,
    OP_ST   = 2'd1,
    OP_BR   = 2'd2,
    OP_JALR = 2'd3
  } rob_op_t;

  localparam logic [2:0] ST_SB = 3'd0;
  localparam logic [2:0] ST_SH = 3'd1;
  localparam logic [2:0] ST_SW = 3'd2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int unsigned ROB_DEPTH_DEF = 8;
  typedef logic [$clog2(ROB_DEPTH_DEF)-1:0] rob_tag_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    rob_op_t     op;
    logic [4:0]  rd;
    logic [2:0]  st_type;
    logic [31:0] val;
    logic [31:0] addr;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_mc_if.sv
// Bundle of decoder, CDB, query, regfile, data-cache and predictor signals
// around the reorder buffer. slave = ROB side, master = environment side.
interface reorder_buffer_mc_if #(
  parameter int unsigned ROB_DEPTH    = 8,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned NUM_WB       = 4,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned TAG_W        = $clog2(ROB_DEPTH)
) ();

  logic                      disp_valid;
  logic                      disp_ready;
  logic [1:0]                disp_op;
  logic [4:0]                disp_rd;
  logic [2:0]                disp_store_type;
  logic [TAG_W-1:0]          disp_tag;

  logic [NUM_WB-1:0]         wb_valid;
  logic [NUM_WB*TAG_W-1:0]   wb_tag;
  logic [NUM_WB*32-1:0]      wb_val;
  logic [NUM_WB*32-1:0]      wb_addr;
  logic [NUM_WB-1:0]         wb_mispredict;
  logic [NUM_WB*32-1:0]      wb_target;

  logic [NUM_RD*TAG_W-1:0]   rd_tag;
  logic [NUM_RD-1:0]         rd_ready;
  logic [NUM_RD*32-1:0]      rd_val;

  logic [COMMIT_WIDTH-1:0]       commit_valid;
  logic [COMMIT_WIDTH*5-1:0]     commit_rd;
  logic [COMMIT_WIDTH*32-1:0]    commit_val;
  logic [COMMIT_WIDTH*TAG_W-1:0] commit_tag;

  logic                      mem_write;
  logic [31:0]               mem_address;
  logic [31:0]               mem_wdata;
  logic [3:0]                mem_byte_enable;
  logic                      mem_resp;

  logic                      flush;
  logic [31:0]               pc_correct;
  logic [31:0]               mispredict_pc;
  logic                      br_mispredict;
  logic                      jalr_mispredict;
  logic                      trap;

  modport slave (
    input  disp_valid, disp_op, disp_rd, disp_store_type,
    input  wb_valid, wb_tag, wb_val, wb_addr, wb_mispredict, wb_target,
    input  rd_tag, mem_resp,
    output disp_ready, disp_tag, rd_ready, rd_val,
    output commit_valid, commit_rd, commit_val, commit_tag,
    output mem_write, mem_address, mem_wdata, mem_byte_enable,
    output flush, pc_correct, mispredict_pc, br_mispredict, jalr_mispredict, trap
  );

  modport master (
    output disp_valid, disp_op, disp_rd, disp_store_type,
    output wb_valid, wb_tag, wb_val, wb_addr, wb_mispredict, wb_target,
    output rd_tag, mem_resp,
    input  disp_ready, disp_tag, rd_ready, rd_val,
    input  commit_valid, commit_rd, commit_val, commit_tag,
    input  mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  flush, pc_correct, mispredict_pc, br_mispredict, jalr_mispredict, trap
  );

endinterface

// File: rtl/reorder_buffer_mc_store_unit.sv
// Store drain FSM: issues the head store to the data cache, holds the request
// until mem_resp, and produces the byte mask and lane-rotated write data.
module rob_store_unit
  import reorder_buffer_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  st_type_i,
  input  logic        mem_resp_i,
  output logic        done_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_byte_enable_o
);

  logic [0:0]  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] addr_c, wdata_c;
  logic [3:0]  be_c;
  logic [63:0] rot;

  always_comb begin
    addr_c  = {addr_i[31:2], 2'b00};
    rot     = {data_i, data_i} << {addr_i[1:0], 3'b000};
    wdata_c = rot[63:32];
    case (st_type_i)
      ST_SW:   be_c = 4'b1111;
      ST_SH:   be_c = addr_i[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b0001 << addr_i[1:0];
    endcase
  end

  // Request is combinational from the head entry on the first cycle, then held in registers.
  always_comb begin
    state_d           = state_q;
    done_o            = 1'b0;
    mem_write_o       = 1'b0;
    mem_address_o     = '0;
    mem_wdata_o       = '0;
    mem_byte_enable_o = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mem_write_o       = 1'b1;
          mem_address_o     = addr_c;
          mem_wdata_o       = wdata_c;
          mem_byte_enable_o = be_c;
          state_d           = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_write_o       = 1'b1;
        mem_address_o     = addr_q;
        mem_wdata_o       = wdata_q;
        mem_byte_enable_o = be_q;
        if (mem_resp_i) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        addr_q  <= addr_c;
        wdata_q <= wdata_c;
        be_q    <= be_c;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Reorder buffer with NUM_WB writeback channels and up to COMMIT_WIDTH retirements
// per cycle. Optional counters enabled by defining ROB_PERF_CNT_EN.
module reorder_buffer_mc
  import reorder_buffer_mc_pkg::*;
#(
  parameter int unsigned ROB_DEPTH    = 8,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned NUM_WB       = 4,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned TAG_W        = $clog2(ROB_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  reorder_buffer_mc_if.slave bus
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_flushes,
  output logic [31:0]        perf_full_cycles
`endif
);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   cnt_t;

  tag_t       head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d, num_ret;
  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];
  tag_t       slot_idx  [COMMIT_WIDTH];
  rob_entry_t slot_e    [COMMIT_WIDTH];
  tag_t       wb_tag_w  [NUM_WB];
  tag_t       rd_tag_w  [NUM_RD];
  rob_entry_t head_e, disp_entry;
  logic [COMMIT_WIDTH-1:0] retire;
  logic       chain_ok, flush_c, accept, st_start, st_done;

  assign bus.disp_ready = (count_q < cnt_t'(ROB_DEPTH));
  assign bus.disp_tag   = tail_q;
  assign accept         = bus.disp_valid && bus.disp_ready && !flush_c;
  assign head_e         = entries_q[head_q];
  assign st_start       = (count_q != '0) && head_e.valid && head_e.ready && (head_e.op == OP_ST);

  always_comb begin
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx[k] = head_q + tag_t'(k);
      slot_e[k]   = entries_q[slot_idx[k]];
    end
    for (int unsigned w = 0; w < NUM_WB; w++) wb_tag_w[w] = bus.wb_tag[w*TAG_W +: TAG_W];
    for (int unsigned r = 0; r < NUM_RD; r++) rd_tag_w[r] = bus.rd_tag[r*TAG_W +: TAG_W];
  end

  rob_store_unit u_store (
    .clk               (clk),
    .rst               (rst),
    .start_i           (st_start),
    .flush_i           (flush_c),
    .addr_i            (head_e.addr),
    .data_i            (head_e.val),
    .st_type_i         (head_e.st_type),
    .mem_resp_i        (bus.mem_resp),
    .done_o            (st_done),
    .mem_write_o       (bus.mem_write),
    .mem_address_o     (bus.mem_address),
    .mem_wdata_o       (bus.mem_wdata),
    .mem_byte_enable_o (bus.mem_byte_enable)
  );

  // Retirement walks slots in order; the first blocked slot, a store, or a mispredict ends the group.
  always_comb begin
    retire               = '0;
    chain_ok             = 1'b1;
    flush_c              = 1'b0;
    bus.commit_valid     = '0;
    bus.commit_rd        = '0;
    bus.commit_val       = '0;
    bus.commit_tag       = '0;
    bus.pc_correct       = '0;
    bus.mispredict_pc    = '0;
    bus.br_mispredict    = 1'b0;
    bus.jalr_mispredict  = 1'b0;
    bus.trap             = 1'b0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (chain_ok && (cnt_t'(k) < count_q) && slot_e[k].ready) begin
        if (slot_e[k].op == OP_ST) begin
          retire[k] = (k == 0) && st_done;
          chain_ok  = 1'b0;
        end else begin
          retire[k] = 1'b1;
          if (slot_e[k].op != OP_BR) begin
            bus.commit_valid[k]             = 1'b1;
            bus.commit_rd[k*5 +: 5]         = slot_e[k].rd;
            bus.commit_val[k*32 +: 32]      = slot_e[k].val;
            bus.commit_tag[k*TAG_W +: TAG_W] = slot_idx[k];
          end
          if (slot_e[k].op != OP_REG && slot_e[k].mispredict) begin
            flush_c             = 1'b1;
            bus.pc_correct      = slot_e[k].target;
            bus.mispredict_pc   = slot_e[k].addr;
            bus.br_mispredict   = (slot_e[k].op == OP_BR);
            bus.jalr_mispredict = (slot_e[k].op == OP_JALR);
            bus.trap            = (slot_e[k].target == slot_e[k].addr);
            chain_ok            = 1'b0;
          end
        end
      end else begin
        chain_ok = 1'b0;
      end
    end
    bus.flush = flush_c;
  end

  always_comb begin
    num_ret = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) num_ret = num_ret + cnt_t'(retire[k]);
  end

  // Operand query with same-cycle writeback bypass; the lowest channel wins.
  always_comb begin
    bus.rd_ready = '0;
    bus.rd_val   = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      bus.rd_ready[r]        = entries_q[rd_tag_w[r]].valid && entries_q[rd_tag_w[r]].ready;
      bus.rd_val[r*32 +: 32] = entries_q[rd_tag_w[r]].val;
      for (int unsigned w = NUM_WB; w > 0; w--) begin
        if (bus.wb_valid[w-1] && entries_q[rd_tag_w[r]].valid && (wb_tag_w[w-1] == rd_tag_w[r])) begin
          bus.rd_ready[r]        = 1'b1;
          bus.rd_val[r*32 +: 32] = bus.wb_val[(w-1)*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.op      = rob_op_t'(bus.disp_op);
    disp_entry.rd      = bus.disp_rd;
    disp_entry.st_type = bus.disp_store_type;
  end

  always_comb begin
    entries_d = entries_q;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (retire[k]) entries_d[slot_idx[k]].valid = 1'b0;
    end
    for (int unsigned w = 0; w < NUM_WB; w++) begin
      if (bus.wb_valid[w] && entries_q[wb_tag_w[w]].valid) begin
        entries_d[wb_tag_w[w]].ready      = 1'b1;
        entries_d[wb_tag_w[w]].val        = bus.wb_val[w*32 +: 32];
        entries_d[wb_tag_w[w]].addr       = bus.wb_addr[w*32 +: 32];
        entries_d[wb_tag_w[w]].mispredict = bus.wb_mispredict[w];
        entries_d[wb_tag_w[w]].target     = bus.wb_target[w*32 +: 32];
      end
    end
    if (accept) entries_d[tail_q] = disp_entry;
    head_d  = head_q + tag_t'(num_ret);
    tail_d  = accept ? tail_q + tag_t'(1) : tail_q;
    count_d = count_q + cnt_t'(accept) - num_ret;
    if (flush_c) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) entries_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_flushes_q, perf_full_q;
  logic [32:0] ret_sum;

  assign ret_sum = {1'b0, perf_retired_q} + 33'(num_ret);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
      perf_full_q    <= '0;
    end else begin
      perf_retired_q <= ret_sum[32] ? '1 : ret_sum[31:0];
      if (flush_c && perf_flushes_q != '1) perf_flushes_q <= perf_flushes_q + 32'd1;
      if (!bus.disp_ready && perf_full_q != '1) perf_full_q <= perf_full_q + 32'd1;
    end
  end

  assign perf_retired     = perf_retired_q;
  assign perf_flushes     = perf_flushes_q;
  assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc at depth 8, two commit slots, four writeback channels.
module tb_reorder_buffer_mc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reorder_buffer_mc_if #(.ROB_DEPTH(8), .COMMIT_WIDTH(2), .NUM_WB(4), .NUM_RD(2)) bus ();

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired, perf_flushes, perf_full_cycles;
`endif

  reorder_buffer_mc #(.ROB_DEPTH(8), .COMMIT_WIDTH(2), .NUM_WB(4), .NUM_RD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_retired     (perf_retired),
    .perf_flushes     (perf_flushes),
    .perf_full_cycles (perf_full_cycles)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [1:0] op, input logic [4:0] rd, input logic [2:0] st);
    bus.disp_valid      = 1'b1;
    bus.disp_op         = op;
    bus.disp_rd         = rd;
    bus.disp_store_type = st;
    step();
    bus.disp_valid      = 1'b0;
  endtask

  task automatic wb(input int ch, input logic [2:0] tag, input logic [31:0] val,
                    input logic [31:0] addr, input logic misp, input logic [31:0] tgt);
    bus.wb_valid[ch]           = 1'b1;
    bus.wb_tag[ch*3 +: 3]      = tag;
    bus.wb_val[ch*32 +: 32]    = val;
    bus.wb_addr[ch*32 +: 32]   = addr;
    bus.wb_mispredict[ch]      = misp;
    bus.wb_target[ch*32 +: 32] = tgt;
  endtask

  task automatic clear_wb();
    bus.wb_valid      = '0;
    bus.wb_tag        = '0;
    bus.wb_val        = '0;
    bus.wb_addr       = '0;
    bus.wb_mispredict = '0;
    bus.wb_target     = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got=%0h exp=1", bus.disp_ready); end
    checks++; if (bus.disp_tag !== 3'd0) begin errors++; $display("FAIL reset_disp_tag got=%0h exp=0", bus.disp_tag); end
    checks++; if (bus.commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit_valid got=%0b exp=00", bus.commit_valid); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%0h exp=0", bus.mem_write); end
    checks++; if (bus.flush !== 1'b0 || bus.trap !== 1'b0) begin errors++; $display("FAIL reset_flush_trap got=%0h%0h exp=00", bus.flush, bus.trap); end
    checks++; if (bus.rd_ready !== 2'b00) begin errors++; $display("FAIL reset_rd_ready got=%0b exp=00", bus.rd_ready); end
    @(posedge clk);
    #3 rst = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.disp_tag !== 3'(i)) begin errors++; $display("FAIL fill_tag got=%0d exp=%0d", bus.disp_tag, i); end
      checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL fill_ready got=%0h exp=1 at %0d", bus.disp_ready, i); end
      dispatch(2'd0, 5'(i + 1), 3'd0);
    end
    checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0h exp=0", bus.disp_ready); end
    checks++; if (dut.count_q !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", dut.count_q); end
    dispatch(2'd0, 5'd31, 3'd0);
    checks++; if (dut.count_q !== 4'd8) begin errors++; $display("FAIL full_drop_count got=%0d exp=8", dut.count_q); end
    checks++; if (bus.disp_tag !== 3'd0) begin errors++; $display("FAIL full_tag got=%0d exp=0", bus.disp_tag); end
  endtask

  task automatic test_wb_pair();
    wb(0, 3'd0, 32'h11, 32'h0, 1'b0, 32'h0);
    wb(1, 3'd1, 32'h22, 32'h0, 1'b0, 32'h0);
    bus.rd_tag = {3'd5, 3'd1};
    #1;
    checks++; if (bus.commit_valid !== 2'b00) begin errors++; $display("FAIL pair_early got=%0b exp=00", bus.commit_valid); end
    checks++; if (bus.rd_ready !== 2'b01 || bus.rd_val[31:0] !== 32'h22) begin errors++; $display("FAIL bypass got=%0b/%0h exp=01/22", bus.rd_ready, bus.rd_val[31:0]); end
    step(); clear_wb(); #1;
    checks++; if (bus.commit_valid !== 2'b11) begin errors++; $display("FAIL pair_valid got=%0b exp=11", bus.commit_valid); end
    checks++; if (bus.commit_rd !== {5'd2, 5'd1}) begin errors++; $display("FAIL pair_rd got=%0h exp=%0h", bus.commit_rd, {5'd2, 5'd1}); end
    checks++; if (bus.commit_val !== {32'h22, 32'h11}) begin errors++; $display("FAIL pair_val got=%0h exp=2200000011", bus.commit_val); end
    checks++; if (bus.commit_tag !== {3'd1, 3'd0}) begin errors++; $display("FAIL pair_tag got=%0h exp=8", bus.commit_tag); end
    step();
    checks++; if (dut.count_q !== 4'd6) begin errors++; $display("FAIL pair_count got=%0d exp=6", dut.count_q); end
  endtask

  task automatic test_out_of_order();
    wb(0, 3'd3, 32'h33, 32'h0, 1'b0, 32'h0);
    #1;
    checks++; if (bus.commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait1 got=%0b exp=00", bus.commit_valid); end
    step(); clear_wb();
    bus.rd_tag = {3'd2, 3'd3};
    wb(2, 3'd2, 32'h44, 32'h0, 1'b0, 32'h0);
    #1;
    checks++; if (bus.commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait2 got=%0b exp=00", bus.commit_valid); end
    checks++; if (bus.rd_ready !== 2'b11 || bus.rd_val !== {32'h44, 32'h33}) begin errors++; $display("FAIL ooo_query got=%0b/%0h exp=11/4400000033", bus.rd_ready, bus.rd_val); end
    step(); clear_wb(); #1;
    checks++; if (bus.commit_valid !== 2'b11 || bus.commit_val !== {32'h33, 32'h44}) begin errors++; $display("FAIL ooo_commit got=%0b/%0h exp=11/3300000044", bus.commit_valid, bus.commit_val); end
    checks++; if (bus.commit_rd !== {5'd4, 5'd3}) begin errors++; $display("FAIL ooo_rd got=%0h exp=%0h", bus.commit_rd, {5'd4, 5'd3}); end
    step();
    checks++; if (dut.count_q !== 4'd4) begin errors++; $display("FAIL ooo_count got=%0d exp=4", dut.count_q); end
    for (int t = 4; t < 8; t++) wb(t - 4, 3'(t), 32'(t), 32'h0, 1'b0, 32'h0);
    step(); clear_wb(); #1;
    checks++; if (bus.commit_valid !== 2'b11 || bus.commit_rd !== {5'd6, 5'd5}) begin errors++; $display("FAIL drain1 got=%0b/%0h exp=11/%0h", bus.commit_valid, bus.commit_rd, {5'd6, 5'd5}); end
    step(); #1;
    checks++; if (bus.commit_valid !== 2'b11 || bus.commit_tag !== {3'd7, 3'd6}) begin errors++; $display("FAIL drain2 got=%0b/%0h exp=11/3e", bus.commit_valid, bus.commit_tag); end
    step();
    checks++; if (bus.commit_valid !== 2'b00 || dut.count_q !== 4'd0) begin errors++; $display("FAIL drain_empty got=%0b/%0d exp=00/0", bus.commit_valid, dut.count_q); end
  endtask

  task automatic test_store_sb();
    dispatch(2'd1, 5'd0, 3'd0);
    dispatch(2'd0, 5'd9, 3'd0);
    wb(0, 3'd0, 32'hAB, 32'h1003, 1'b0, 32'h0);
    wb(1, 3'd1, 32'h99, 32'h0, 1'b0, 32'h0);
    #1;
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL st_early got=%0h exp=0", bus.mem_write); end
    step(); clear_wb(); #1;
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h1000) begin errors++; $display("FAIL st_issue got=%0h/%0h exp=1/1000", bus.mem_write, bus.mem_address); end
    checks++; if (bus.mem_byte_enable !== 4'b1000 || bus.mem_wdata !== 32'hAB000000) begin errors++; $display("FAIL st_lane got=%0b/%0h exp=1000/ab000000", bus.mem_byte_enable, bus.mem_wdata); end
    checks++; if (bus.commit_valid !== 2'b00) begin errors++; $display("FAIL st_issue_commit got=%0b exp=00", bus.commit_valid); end
    step();
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h1000 || bus.mem_wdata !== 32'hAB000000 || bus.mem_byte_enable !== 4'b1000) begin errors++; $display("FAIL st_hold got=%0h/%0h/%0h/%0b cycle %0d", bus.mem_write, bus.mem_address, bus.mem_wdata, bus.mem_byte_enable, c); end
      checks++; if (bus.commit_valid !== 2'b00 || dut.count_q !== 4'd2) begin errors++; $display("FAIL st_wait got=%0b/%0d exp=00/2", bus.commit_valid, dut.count_q); end
      step();
    end
    bus.mem_resp = 1'b1;
    #1;
    checks++; if (bus.commit_valid !== 2'b00 || bus.mem_write !== 1'b1) begin errors++; $display("FAIL st_resp got=%0b/%0h exp=00/1", bus.commit_valid, bus.mem_write); end
    step();
    bus.mem_resp = 1'b0;
    #1;
    checks++; if (dut.count_q !== 4'd1) begin errors++; $display("FAIL st_retired_count got=%0d exp=1", dut.count_q); end
    checks++; if (bus.commit_valid !== 2'b01 || bus.commit_rd[4:0] !== 5'd9 || bus.commit_val[31:0] !== 32'h99) begin errors++; $display("FAIL st_behind got=%0b/%0d/%0h exp=01/9/99", bus.commit_valid, bus.commit_rd[4:0], bus.commit_val[31:0]); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL st_release got=%0h exp=0", bus.mem_write); end
    step();
  endtask

  task automatic test_store_lanes();
    logic [2:0]  typ  [3] = '{3'd2, 3'd1, 3'd0};
    logic [31:0] addr [3] = '{32'h3000, 32'h2002, 32'h1001};
    logic [31:0] data [3] = '{32'hDEADBEEF, 32'h00001234, 32'h000000CD};
    logic [3:0]  ebe  [3] = '{4'b1111, 4'b1100, 4'b0010};
    logic [31:0] ewd  [3] = '{32'hDEADBEEF, 32'h12340000, 32'h0000CD00};
    logic [31:0] eadr [3] = '{32'h3000, 32'h2000, 32'h1000};
    for (int v = 0; v < 3; v++) begin
      wb(0, 3'(2 + v), data[v], addr[v], 1'b0, 32'h0);
      dispatch(2'd1, 5'd0, typ[v]);
      step(); clear_wb(); #1;
      checks++; if (bus.mem_byte_enable !== ebe[v] || bus.mem_wdata !== ewd[v] || bus.mem_address !== eadr[v]) begin errors++; $display("FAIL lane%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", v, bus.mem_byte_enable, bus.mem_wdata, bus.mem_address, ebe[v], ewd[v], eadr[v]); end
      step();
      bus.mem_resp = 1'b1;
      step();
      bus.mem_resp = 1'b0;
    end
    checks++; if (dut.count_q !== 4'd0 || bus.disp_tag !== 3'd5) begin errors++; $display("FAIL lanes_end got=%0d/%0d exp=0/5", dut.count_q, bus.disp_tag); end
  endtask

  task automatic test_mispredict();
    dispatch(2'd2, 5'd0, 3'd0);
    dispatch(2'd0, 5'd5, 3'd0);
    wb(0, 3'd5, 32'h0, 32'h40, 1'b1, 32'h60);
    wb(1, 3'd6, 32'h55, 32'h0, 1'b0, 32'h0);
    step(); clear_wb();
    bus.disp_valid = 1'b1; bus.disp_op = 2'd0; bus.disp_rd = 5'd7;
    #1;
    checks++; if (bus.flush !== 1'b1 || bus.pc_correct !== 32'h60 || bus.mispredict_pc !== 32'h40) begin errors++; $display("FAIL br_flush got=%0h/%0h/%0h exp=1/60/40", bus.flush, bus.pc_correct, bus.mispredict_pc); end
    checks++; if (bus.br_mispredict !== 1'b1 || bus.jalr_mispredict !== 1'b0 || bus.trap !== 1'b0) begin errors++; $display("FAIL br_type got=%0h%0h%0h exp=100", bus.br_mispredict, bus.jalr_mispredict, bus.trap); end
    checks++; if (bus.commit_valid !== 2'b00) begin errors++; $display("FAIL br_suppress got=%0b exp=00", bus.commit_valid); end
    step();
    bus.disp_valid = 1'b0;
    #1;
    checks++; if (dut.count_q !== 4'd0 || bus.disp_tag !== 3'd0 || bus.flush !== 1'b0) begin errors++; $display("FAIL br_after got=%0d/%0d/%0h exp=0/0/0", dut.count_q, bus.disp_tag, bus.flush); end
  endtask

  task automatic test_trap();
    dispatch(2'd3, 5'd6, 3'd0);
    wb(3, 3'd0, 32'h84, 32'h80, 1'b1, 32'h80);
    step(); clear_wb(); #1;
    checks++; if (bus.flush !== 1'b1 || bus.trap !== 1'b1 || bus.pc_correct !== 32'h80) begin errors++; $display("FAIL trap got=%0h/%0h/%0h exp=1/1/80", bus.flush, bus.trap, bus.pc_correct); end
    checks++; if (bus.jalr_mispredict !== 1'b1 || bus.br_mispredict !== 1'b0) begin errors++; $display("FAIL trap_type got=%0h%0h exp=10", bus.jalr_mispredict, bus.br_mispredict); end
    checks++; if (bus.commit_valid !== 2'b01 || bus.commit_rd[4:0] !== 5'd6 || bus.commit_val[31:0] !== 32'h84) begin errors++; $display("FAIL jalr_commit got=%0b/%0d/%0h exp=01/6/84", bus.commit_valid, bus.commit_rd[4:0], bus.commit_val[31:0]); end
    step();
    checks++; if (dut.count_q !== 4'd0 || bus.trap !== 1'b0) begin errors++; $display("FAIL trap_after got=%0d/%0h exp=0/0", dut.count_q, bus.trap); end
  endtask

  task automatic test_async_reset();
    dispatch(2'd1, 5'd0, 3'd2);
    wb(0, 3'd0, 32'h5, 32'h200, 1'b0, 32'h0);
    step(); clear_wb(); #1;
    checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0h exp=1", bus.mem_write); end
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.mem_write !== 1'b0 || bus.mem_byte_enable !== 4'b0000 || bus.mem_address !== 32'h0) begin errors++; $display("FAIL arst_mem got=%0h/%0b/%0h exp=0/0/0", bus.mem_write, bus.mem_byte_enable, bus.mem_address); end
    checks++; if (bus.disp_ready !== 1'b1 || bus.disp_tag !== 3'd0) begin errors++; $display("FAIL arst_disp got=%0h/%0d exp=1/0", bus.disp_ready, bus.disp_tag); end
    #2 rst = 1'b1;
    step();
    checks++; if (bus.mem_write !== 1'b0 || dut.count_q !== 4'd0) begin errors++; $display("FAIL arst_after got=%0h/%0d exp=0/0", bus.mem_write, dut.count_q); end
  endtask

  initial begin
    bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_rd = '0; bus.disp_store_type = '0;
    bus.rd_tag = '0; bus.mem_resp = 1'b0;
    clear_wb();
    test_reset();
    test_fill();
    test_wb_pair();
    test_out_of_order();
    test_store_sb();
    test_store_lanes();
    test_mispredict();
    test_trap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
